img_frame_loader: RTL
=====================

Name: img_frame_loader

Overview:
- Writer side of the CNN input buffer. Receives a framed byte stream over a valid/ready interface, checks it, and writes pixels into one half of a double-buffered input memory.
- On a good frame it swaps banks, so the conv1 datapath reads the freshly loaded image while the next one streams in.
- Sits between a UART/byte source and the input memory that feeds conv2d/ReLU/maxpool/fullyconnected.

Parameters:
- in_channels, 1, input channels; matches the conv1 in_channels.
- in_size, 28, image rows = cols.
- data_size, 8, pixel width; equals `DATA_SIZE. Byte stream width equals data_size.
- sync_byte, 8'hA5, frame start marker.
- timeout, 1000, idle cycles mid-frame before abort; 0 disables the timeout.
- Derived: depth = in_channels*in_size**2; aw = $clog2(depth).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  data_size  stream byte.
- in_valid  in  1  byte present.
- in_ready  out  1  loader accepts byte. Transfer occurs when in_valid & in_ready.
- hold  in  1  consumer busy; blocks the start of a new frame.
- wr_en  out  1  memory write strobe.
- wr_bank  out  1  bank written; always ~rd_bank.
- wr_addr  out  aw  linear index c*in_size^2 + r*in_size + col.
- wr_data  out  data_size  pixel.
- rd_bank  out  1  bank the CNN reads.
- frame_done  out  1  1-cycle pulse on a good frame.
- frame_err  out  1  1-cycle pulse on a checksum error or timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Async reset values:
  - state = IDLE.
  - in_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0.
  - rd_bank = 0, frame_done = 0, frame_err = 0, busy = 0.
  - Internal checksum, count and timer = 0.
  - All outputs are registered.
- in_ready:
  - 0 in IDLE when hold = 1.
  - 1 otherwise.
  - Registered from next-state/hold, so it reacts 1 cycle after hold changes.
- IDLE:
  - Accepted byte == sync_byte -> DATA; count = 0, chk = 0, timer = 0.
  - Any other byte is silently dropped.
- DATA:
  - Each accepted byte produces next cycle: wr_en = 1, wr_addr = count, wr_data = byte. Latency is 1 cycle.
  - On each accepted byte: chk ^= byte, count++.
  - The byte that makes count == depth moves the FSM to CHECK.
  - sync_byte inside DATA is ordinary data.
  - wr_en is low in any cycle with no accept.
- CHECK:
  - Accepted byte == chk -> frame_done = 1 and rd_bank toggles in the same cycle.
  - Accepted byte != chk -> frame_err = 1 and rd_bank is unchanged.
  - Either way, the FSM returns to IDLE.
  - No memory write occurs for the checksum byte.
- Timeout (DATA/CHECK only):
  - timer counts cycles with no accepted byte and clears on every accept.
  - When timer reaches timeout: frame_err pulse, go to IDLE, rd_bank unchanged.
  - Bytes already written to wr_bank are left in place; they are harmless because that bank is not being read.
  - timeout = 0 disables the check.
- hold only gates IDLE; a frame already in progress completes regardless of hold.
- Reset mid-frame discards the frame; rd_bank returns to 0.
- Back-to-back frames: a sync byte may be accepted in the cycle right after returning to IDLE.
- frame_done and frame_err are never high together.

Decomposition:
- Shared package cnn_pkg:
  - DATA_SIZE constant.
  - SYNC_BYTE constant.
  - loader_state_t enum {IDLE, DATA, CHECK}.
- Sub-module frame_timer: resettable idle counter with a terminal-count flag, parameterised by timeout.
- FSM, checksum and address counter stay in img_frame_loader.

Test Plan (in_channels=1, in_size=2, depth=4, timeout=16):
- Good frame:
  - Stimulus: reset, then stream A5, 01, 02, 03, 04, 04.
  - Response: writes (addr,data) = (0,01) (1,02) (2,03) (3,04) on wr_bank = 1, each 1 cycle after its accept; then frame_done pulse and rd_bank goes 0 -> 1.
- Bad checksum:
  - Stimulus: A5, 01, 02, 03, 04, 00.
  - Response: four writes, then frame_err pulse; rd_bank stays 0; next frame is accepted normally.
- Leading garbage and embedded sync:
  - Stimulus: 3C, 7E, A5, A5, 00, 00, 00, A5.
  - Response: garbage dropped, no writes before the first A5; data = A5, 00, 00, 00; checksum A5 matches -> frame_done.
- Timeout:
  - Stimulus: A5, 01, 02, then no valid for 16 cycles.
  - Response: frame_err at timer = 16; busy drops; rd_bank unchanged.
- Hold:
  - Stimulus: hold = 1 in IDLE while in_valid = 1 with A5.
  - Response: in_ready = 0 and no accept. Deassert hold -> in_ready = 1 next cycle and the frame proceeds.
  - Stimulus: raise hold mid-DATA.
  - Response: the frame still completes.
- Reset mid-frame:
  - Stimulus: after one good frame (rd_bank = 1), send A5, 01, then assert reset asynchronously.
  - Response: all outputs go to reset values immediately, rd_bank = 0; a subsequent good frame completes.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and types shared by the CNN input path
package cnn_pkg;
  localparam int DATA_SIZE = 8;
  localparam logic [DATA_SIZE-1:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {IDLE, DATA, CHECK} loader_state_t;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: idle-cycle counter; o_tc flags the idle cycle that brings the count to TIMEOUT (0 disables)
module frame_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
  assign o_tc = TIMEOUT != 0 && i_en && int'(r_cnt) == TIMEOUT - 1;
endmodule

// File: rtl/img_frame_loader.sv
// img_frame_loader: checks a framed byte stream (sync, pixels, xor checksum), writes pixels
// into the idle bank of a double-buffered input memory and swaps banks on a good frame
module img_frame_loader
  import cnn_pkg::*;
#(
  parameter int IN_CHANNELS = 1,
  parameter int IN_SIZE = 28,
  parameter int DATA_W = DATA_SIZE,
  parameter logic [DATA_W-1:0] SYNC = SYNC_BYTE,
  parameter int TIMEOUT = 1000,
  localparam int DEPTH = IN_CHANNELS * IN_SIZE * IN_SIZE,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_hold,
  output logic              o_wr_en,
  output logic              o_wr_bank,
  output logic [AW-1:0]     o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_bank,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_busy
);
  loader_state_t r_state, w_next;
  logic r_ready, r_wr_en, r_rd_bank, r_done, r_err;
  logic [AW-1:0] r_cnt, r_wr_addr;
  logic [DATA_W-1:0] r_chk, r_wr_data;
  logic w_acc, w_wr, w_tc, w_done, w_err;
  assign w_acc = i_in_valid & r_ready;
  assign w_wr = w_acc && r_state == DATA;
  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (r_state == IDLE || w_acc),
    .i_en   (r_state != IDLE && !w_acc),
    .o_tc   (w_tc)
  );
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err = 1'b0;
    case (r_state)
      IDLE: w_next = w_acc && i_in_data == SYNC ? DATA : IDLE;
      DATA: begin
        w_next = w_wr && r_cnt == AW'(DEPTH - 1) ? CHECK : w_tc ? IDLE : DATA;
        w_err = w_tc;
      end
      CHECK: begin
        w_next = w_acc || w_tc ? IDLE : CHECK;
        w_done = w_acc && i_in_data == r_chk;
        w_err = w_acc ? i_in_data != r_chk : w_tc;
      end
      default: w_next = IDLE;
    endcase
  end
  // count and checksum are cleared while idle, so they start at zero with every sync byte
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cnt <= '0;
      r_chk <= '0;
      r_rd_bank <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= !(w_next == IDLE && i_hold);
      r_wr_en <= w_wr;
      r_wr_addr <= w_wr ? r_cnt : r_wr_addr;
      r_wr_data <= w_wr ? i_in_data : r_wr_data;
      r_cnt <= r_state == IDLE ? '0 : w_wr ? r_cnt + 1'b1 : r_cnt;
      r_chk <= r_state == IDLE ? '0 : w_wr ? r_chk ^ i_in_data : r_chk;
      r_rd_bank <= r_rd_bank ^ w_done;
      r_done <= w_done;
      r_err <= w_err;
    end
  assign o_in_ready = r_ready;
  assign o_wr_en = r_wr_en;
  assign o_wr_bank = ~r_rd_bank;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_rd_bank = r_rd_bank;
  assign o_frame_done = r_done;
  assign o_frame_err = r_err;
  assign o_busy = r_state != IDLE;
endmodule
